// File: rtl/frp_pkg.sv
// Shared types and constants for the pipelined fanout repeater.
package frp_pkg;

    localparam int MAX_LOADS  = 32;
    localparam int MAX_STAGES = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_e;

    function automatic int branch_slice(input int i, input int width);
        return i * width;
    endfunction

endpackage

// File: rtl/frp_skid_stage.sv
// Two-entry skid register; the upstream ready is a flop so no ready path crosses the stage.
module frp_skid_stage
    import frp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_state
);

    stage_state_e     r_state;
    logic             r_ready;
    logic             r_valid;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_spill;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_valid & r_ready;
    assign w_pop   = r_valid & i_ready;
    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign o_data  = r_head;
    assign o_state = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_head  <= '0;
            r_spill <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        r_head  <= i_data;
                        r_valid <= 1'b1;
                        r_state <= ONE;
                    end
                end
                ONE: begin
                    if (w_push && w_pop) begin
                        r_head <= i_data;
                    end else if (w_push) begin
                        // Head is stalled: park the new beat and close the door upstream.
                        r_spill <= i_data;
                        r_ready <= 1'b0;
                        r_state <= TWO;
                    end else if (w_pop) begin
                        r_valid <= 1'b0;
                        r_state <= EMPTY;
                    end
                end
                TWO: begin
                    if (w_pop) begin
                        r_head  <= r_spill;
                        r_ready <= 1'b1;
                        r_state <= ONE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipelined_fanout_repeater.sv
// Eager-fork of one valid/ready stream into NUM_LOADS branches, each a chain of skid stages.
module pipelined_fanout_repeater
    import frp_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_LOADS = 3,
    parameter int STAGES    = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [NUM_LOADS-1:0]       load_en,
    output logic [NUM_LOADS-1:0]       out_valid,
    input  logic [NUM_LOADS-1:0]       out_ready,
    output logic [NUM_LOADS*WIDTH-1:0] out_data,
    output logic                       all_idle
);

    if (WIDTH < 1) begin : g_bad_width
        $error("WIDTH must be at least 1");
    end
    if (NUM_LOADS < 1 || NUM_LOADS > MAX_LOADS) begin : g_bad_loads
        $error("NUM_LOADS out of range");
    end
    if (STAGES < 0 || STAGES > MAX_STAGES) begin : g_bad_stages
        $error("STAGES out of range");
    end

    logic [NUM_LOADS-1:0] r_sent;
    logic [NUM_LOADS-1:0] w_br_valid;
    logic [NUM_LOADS-1:0] w_br_ready;
    logic [NUM_LOADS-1:0] w_take;
    logic [NUM_LOADS-1:0] w_done;
    logic [NUM_LOADS-1:0] w_busy;

    assign w_br_valid = {NUM_LOADS{in_valid}} & load_en & ~r_sent;
    assign w_take     = w_br_valid & w_br_ready;
    // A disabled branch never blocks the source, even if it had not yet taken the beat.
    assign w_done     = r_sent | ~load_en | w_br_ready;
    assign in_ready   = rst_n & (&w_done);
    assign all_idle   = ~(|r_sent) & ~(|w_busy);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sent <= '0;
        end else if (in_valid && in_ready) begin
            r_sent <= '0;
        end else begin
            r_sent <= r_sent | w_take;
        end
    end

    if (STAGES == 0) begin : g_pass
        assign out_valid  = w_br_valid;
        assign w_br_ready = out_ready;
        assign w_busy     = '0;
        for (genvar i = 0; i < NUM_LOADS; i++) begin : g_br
            assign out_data[branch_slice(i, WIDTH) +: WIDTH] = in_data;
        end
    end else begin : g_pipe
        for (genvar i = 0; i < NUM_LOADS; i++) begin : g_br
            logic [STAGES:0]   w_v;
            logic [STAGES:0]   w_r;
            logic [WIDTH-1:0]  w_d [STAGES+1];
            logic [1:0]        w_st [STAGES];
            logic [STAGES-1:0] w_occ;

            assign w_v[0]        = w_br_valid[i];
            assign w_d[0]        = in_data;
            assign w_br_ready[i] = w_r[0];
            assign w_r[STAGES]   = out_ready[i];
            assign out_valid[i]  = w_v[STAGES];
            assign out_data[branch_slice(i, WIDTH) +: WIDTH] = w_d[STAGES];
            assign w_busy[i]     = |w_occ;

            for (genvar j = 0; j < STAGES; j++) begin : g_stage
                frp_skid_stage #(.WIDTH(WIDTH)) u_stage (
                    .clk     (clk),
                    .rst_n   (rst_n),
                    .i_valid (w_v[j]),
                    .o_ready (w_r[j]),
                    .i_data  (w_d[j]),
                    .o_valid (w_v[j+1]),
                    .i_ready (w_r[j+1]),
                    .o_data  (w_d[j+1]),
                    .o_state (w_st[j])
                );
                assign w_occ[j] = (w_st[j] != EMPTY);
            end
        end
    end

`ifndef SYNTHESIS
    // The source must keep a partially forked beat valid until it retires.
    a_src_hold: assert property (@(posedge clk) disable iff (!rst_n) (|r_sent) |-> in_valid);
`endif

endmodule

// File: tb/tb_pipelined_fanout_repeater.sv
// Directed bench: a 3-branch/2-stage repeater with per-branch expected queues and a 0-stage instance.
module tb_pipelined_fanout_repeater;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        a_in_valid;
    logic        a_in_ready;
    logic [7:0]  a_in_data;
    logic [2:0]  a_load_en;
    logic [2:0]  a_out_valid;
    logic [2:0]  a_out_ready;
    logic [23:0] a_out_data;
    logic        a_all_idle;

    logic        z_in_valid;
    logic        z_in_ready;
    logic [7:0]  z_in_data;
    logic [1:0]  z_load_en;
    logic [1:0]  z_out_valid;
    logic [1:0]  z_out_ready;
    logic [15:0] z_out_data;
    logic        z_all_idle;

    int n_checks = 0;
    int n_pass   = 0;
    int n_waits  = 0;

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    logic [7:0] exp_q2[$];

    always #5 clk = ~clk;

    pipelined_fanout_repeater #(.WIDTH(8), .NUM_LOADS(3), .STAGES(2)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .load_en   (a_load_en),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .all_idle  (a_all_idle)
    );

    pipelined_fanout_repeater #(.WIDTH(8), .NUM_LOADS(2), .STAGES(0)) dut_z (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (z_in_valid),
        .in_ready  (z_in_ready),
        .in_data   (z_in_data),
        .load_en   (z_load_en),
        .out_valid (z_out_valid),
        .out_ready (z_out_ready),
        .out_data  (z_out_data),
        .all_idle  (z_all_idle)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_beat(input int br, input logic [7:0] d);
        case (br)
            0: if (exp_q0.size() == 0) check("br0_extra", 32'd1, 32'd0);
               else check("br0_data", 32'(d), 32'(exp_q0.pop_front()));
            1: if (exp_q1.size() == 0) check("br1_extra", 32'd1, 32'd0);
               else check("br1_data", 32'(d), 32'(exp_q1.pop_front()));
            default: if (exp_q2.size() == 0) check("br2_extra", 32'd1, 32'd0);
               else check("br2_data", 32'(d), 32'(exp_q2.pop_front()));
        endcase
    endtask

    // Every beat that leaves a branch is matched against that branch's queue.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                if (a_out_valid[i] && a_out_ready[i]) check_beat(i, a_out_data[i*8 +: 8]);
            end
        end
    end

    task automatic expect_beat(input logic [2:0] mask, input logic [7:0] d);
        if (mask[0]) exp_q0.push_back(d);
        if (mask[1]) exp_q1.push_back(d);
        if (mask[2]) exp_q2.push_back(d);
    endtask

    task automatic send_beat(input logic [7:0] d);
        int n;
        n = 0;
        a_in_valid = 1'b1;
        a_in_data  = d;
        @(negedge clk);
        while (!a_in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        n_waits += n;
        check("send_accepted", 32'(a_in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!(a_all_idle && exp_q0.size() == 0 && exp_q1.size() == 0 && exp_q2.size() == 0)
               && n < 200) begin
            n++;
            @(negedge clk);
        end
        check(tag, 32'(a_all_idle && exp_q0.size() == 0 && exp_q1.size() == 0
                       && exp_q2.size() == 0), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 8'h99;
        a_load_en   = 3'b111;
        a_out_ready = 3'b111;
        z_in_valid  = 1'b0;
        z_in_data   = 8'h00;
        z_load_en   = 2'b11;
        z_out_ready = 2'b11;

        // Reset with a valid source held high
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t1_in_ready", 32'(a_in_ready), 32'd0);
        check("t1_out_valid", 32'(a_out_valid), 32'd0);
        check("t1_idle", 32'(a_all_idle), 32'd1);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        a_in_valid = 1'b0;
        @(negedge clk);
        check("t1_ready_after", 32'(a_in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Broadcast 0x01..0x10 to every branch
        for (int d = 1; d <= 16; d++) expect_beat(3'b111, 8'(d));
        n_waits = 0;
        send_beat(8'h01);
        check("t2_lat0", 32'(a_out_valid), 32'h0);
        send_beat(8'h02);
        check("t2_lat1", 32'(a_out_valid), 32'h7);
        for (int d = 3; d <= 16; d++) send_beat(8'(d));
        a_in_valid = 1'b0;
        check("t2_no_stall", 32'(n_waits), 32'd0);
        drain("t2_drain");

        // Branch 1 stalled
        a_out_ready = 3'b101;
        for (int d = 8'hA0; d <= 8'hA7; d++) expect_beat(3'b111, 8'(d));
        for (int d = 8'hA0; d <= 8'hA3; d++) send_beat(8'(d));
        a_in_valid = 1'b1;
        a_in_data  = 8'hA4;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("t3_in_ready", 32'(a_in_ready), 32'd0);
        check("t3_sent", 32'(dut_a.r_sent), 32'h5);
        check("t3_out_valid", 32'(a_out_valid), 32'h2);
        @(posedge clk);
        #1;
        a_out_ready = 3'b111;
        send_beat(8'hA4);
        for (int d = 8'hA5; d <= 8'hA7; d++) send_beat(8'(d));
        a_in_valid = 1'b0;
        drain("t3_drain");

        // Disable branch 2 while 0x55 is pending on it
        a_out_ready = 3'b011;
        for (int d = 8'h51; d <= 8'h54; d++) expect_beat(3'b111, 8'(d));
        expect_beat(3'b011, 8'h55);
        for (int d = 8'h51; d <= 8'h54; d++) send_beat(8'(d));
        a_in_valid = 1'b1;
        a_in_data  = 8'h55;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t4_stall", 32'(a_in_ready), 32'd0);
        @(posedge clk);
        #1;
        a_load_en = 3'b011;
        @(negedge clk);
        check("t4_dis_ready", 32'(a_in_ready), 32'd1);
        @(posedge clk);
        #1;
        a_in_valid  = 1'b0;
        a_out_ready = 3'b111;
        drain("t4_drain");
        a_load_en = 3'b111;

        // No branch enabled: beats are dropped
        a_load_en  = 3'b000;
        a_in_valid = 1'b1;
        a_in_data  = 8'hEE;
        @(negedge clk);
        check("t4z_in_ready", 32'(a_in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        @(negedge clk);
        check("t4z_out_valid", 32'(a_out_valid), 32'h0);
        check("t4z_idle", 32'(a_all_idle), 32'd1);
        @(posedge clk);
        #1;
        a_load_en = 3'b111;

        // Zero-stage instance is combinational
        z_in_valid = 1'b1;
        z_in_data  = 8'h3C;
        #1;
        check("t5_data", 32'(z_out_data), 32'h3C3C);
        check("t5_valid", 32'(z_out_valid), 32'h3);
        check("t5_ready", 32'(z_in_ready), 32'd1);
        z_out_ready = 2'b01;
        #1;
        check("t5_stall", 32'(z_in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("t5_valid_sent", 32'(z_out_valid), 32'h2);
        check("t5_stall_held", 32'(z_in_ready), 32'd0);
        z_out_ready = 2'b11;
        #1;
        check("t5_release", 32'(z_in_ready), 32'd1);
        @(posedge clk);
        #1;
        check("t5_fresh_beat", 32'(z_out_valid), 32'h3);
        z_in_valid = 1'b0;
        #1;
        check("t5_no_valid", 32'(z_out_valid), 32'h0);
        z_load_en  = 2'b01;
        z_in_valid = 1'b1;
        z_in_data  = 8'h5A;
        #1;
        check("t5_en_mask", 32'(z_out_valid), 32'h1);
        check("t5_en_data", 32'(z_out_data[7:0]), 32'h5A);
        @(posedge clk);
        #1;
        z_in_valid = 1'b0;

        // Reset while three beats are in flight
        a_out_ready = 3'b000;
        send_beat(8'hC1);
        send_beat(8'hC2);
        send_beat(8'hC3);
        a_in_valid = 1'b0;
        check("t6_inflight", 32'(a_out_valid), 32'h7);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(a_out_valid), 32'h0);
        check("t6_rst_ready", 32'(a_in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        a_out_ready = 3'b111;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("t6_no_stale", 32'(a_out_valid), 32'h0);
        check("t6_idle", 32'(a_all_idle), 32'd1);
        check("t6_queues", 32'(exp_q0.size() + exp_q1.size() + exp_q2.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
